switch_debouncer: RTL and testbench

- Input conditioning stage for the board switches (chaveA/chaveB and similar) that feed the xorgate logic and the other class combinational blocks.
- Synchronises each raw, asynchronous switch into the clock domain and filters contact bounce.
- Outputs a clean level per channel, plus single-cycle rise and fall pulses for downstream sequential blocks.
- Its sw_db outputs connect directly to the a/b inputs of xorgate.

---
 rtl/switch_debouncer.sv | 52 +++++
 tb/tb_switch_debouncer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - two-flop synchroniser and per-channel bounce filter with edge pulses
module switch_debouncer #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    localparam int CNT_W          = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [CNT_W-1:0] cnt [WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= '0;
            sync2   <= '0;
            sw_db   <= '0;
            sw_rise <= '0;
            sw_fall <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
            for (int i = 0; i < WIDTH; i++) begin
                sw_rise[i] <= 1'b0;
                sw_fall[i] <= 1'b0;
                // Any cycle agreeing with the accepted level restarts the stability window.
                if (sync2[i] == sw_db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] != CNT_LAST) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end else begin
                    sw_db[i]   <= sync2[i];
                    sw_rise[i] <= sync2[i];
                    sw_fall[i] <= ~sync2[i];
                    cnt[i]     <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// tb/tb_switch_debouncer.sv - scoreboard bench for switch_debouncer (WIDTH=2, DEBOUNCE_CYCLES=4)
module tb_switch_debouncer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] sw_raw = 2'b00;
    logic [1:0] sw_db;
    logic [1:0] sw_rise;
    logic [1:0] sw_fall;
    logic       c;

    int total = 0;
    int bad = 0;
    int edge_cnt = 0;
    int c_toggles = 0;

    typedef struct {
        int         edge_no;
        logic [1:0] rise;
        logic [1:0] fall;
        logic [1:0] db;
    } ev_t;

    ev_t sb[$];

    switch_debouncer #(.WIDTH(2), .DEBOUNCE_CYCLES(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sw_raw  (sw_raw),
        .sw_db   (sw_db),
        .sw_rise (sw_rise),
        .sw_fall (sw_fall)
    );

    // Stand-in for the downstream xorgate fed by sw_db.
    assign c = sw_db[0] ^ sw_db[1];

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt++;

    always @(c) c_toggles++;

    // Every pulse must match the front of the scoreboard; an expected pulse that never came is flagged.
    always @(negedge clk) begin
        ev_t ev;
        if ((sw_rise | sw_fall) !== 2'b00) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL pulse_unexpected: edge=%0d rise=%b fall=%b db=%b, required no pulse",
                         edge_cnt, sw_rise, sw_fall, sw_db);
            end else begin
                ev = sb.pop_front();
                if (ev.edge_no !== edge_cnt || ev.rise !== sw_rise || ev.fall !== sw_fall || ev.db !== sw_db) begin
                    bad++;
                    $display("FAIL pulse_match: got edge=%0d rise=%b fall=%b db=%b, required edge=%0d rise=%b fall=%b db=%b",
                             edge_cnt, sw_rise, sw_fall, sw_db, ev.edge_no, ev.rise, ev.fall, ev.db);
                end
            end
        end else if (sb.size() != 0 && sb[0].edge_no <= edge_cnt) begin
            total++;
            bad++;
            ev = sb.pop_front();
            $display("FAIL pulse_missing: no pulse at edge=%0d, required rise=%b fall=%b db=%b",
                     ev.edge_no, ev.rise, ev.fall, ev.db);
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    endtask

    task automatic drive(input logic [1:0] raw, output int cap_edge);
        @(negedge clk);
        sw_raw   = raw;
        cap_edge = edge_cnt + 1;
    endtask

    task automatic test_reset();
        int e;
        sw_raw = 2'b11;
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({sw_db, sw_rise, sw_fall} !== 6'b0) begin
            bad++;
            $display("FAIL reset_async: db=%b rise=%b fall=%b, required all 0", sw_db, sw_rise, sw_fall);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if ({sw_db, sw_rise, sw_fall} !== 6'b0) begin
                bad++;
                $display("FAIL reset_hold: cycle=%0d db=%b rise=%b fall=%b, required all 0", i, sw_db, sw_rise, sw_fall);
            end
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        e = edge_cnt + 1;
        sb.push_back('{e + 5, 2'b11, 2'b00, 2'b11});
        wait_drain();
        total++;
        if (sb.size() != 0 || sw_db !== 2'b11) begin
            bad++;
            $display("FAIL reset_release: db=%b pending=%0d, required db=11 pending=0", sw_db, sb.size());
        end
    endtask

    task automatic test_clean_rise_fall();
        int e;
        drive(2'b10, e);
        sb.push_back('{e + 5, 2'b00, 2'b01, 2'b10});
        wait_drain();
        drive(2'b11, e);
        sb.push_back('{e + 5, 2'b01, 2'b00, 2'b11});
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            total++;
            if (sw_db !== 2'b10) begin
                bad++;
                $display("FAIL rise_early: k=%0d db=%b, required 10", k, sw_db);
            end
        end
        @(negedge clk);
        total++;
        if (sw_db !== 2'b11 || sw_rise !== 2'b01) begin
            bad++;
            $display("FAIL rise_latency: db=%b rise=%b, required db=11 rise=01", sw_db, sw_rise);
        end
        @(negedge clk);
        total++;
        if (sw_rise !== 2'b00 || sw_db[1] !== 1'b1) begin
            bad++;
            $display("FAIL rise_width: rise=%b db=%b, required rise=00 db[1]=1", sw_rise, sw_db);
        end
        drive(2'b10, e);
        sb.push_back('{e + 5, 2'b00, 2'b01, 2'b10});
        wait_drain();
        total++;
        if (sb.size() != 0 || sw_db !== 2'b10) begin
            bad++;
            $display("FAIL fall_ch0: db=%b pending=%0d, required db=10 pending=0", sw_db, sb.size());
        end
    endtask

    task automatic test_bounce();
        logic [5:0] pat;
        int         e;
        pat = 6'b101101;
        e = 0;
        for (int i = 0; i < 6; i++) begin
            drive({1'b1, pat[5-i]}, e);
            total++;
            if (sw_db !== 2'b10) begin
                bad++;
                $display("FAIL bounce_hold: step=%0d db=%b, required 10", i, sw_db);
            end
        end
        sb.push_back('{e + 5, 2'b01, 2'b00, 2'b11});
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            total++;
            if (sw_db !== 2'b10) begin
                bad++;
                $display("FAIL bounce_early: k=%0d db=%b, required 10", k, sw_db);
            end
        end
        wait_drain();
        total++;
        if (sb.size() != 0 || sw_db !== 2'b11) begin
            bad++;
            $display("FAIL bounce_settle: db=%b pending=%0d, required db=11 pending=0", sw_db, sb.size());
        end
    endtask

    task automatic test_glitch();
        int e;
        drive(2'b01, e);
        sb.push_back('{e + 5, 2'b00, 2'b10, 2'b01});
        wait_drain();
        drive(2'b11, e);
        repeat (2) @(negedge clk);
        drive(2'b01, e);
        repeat (15) @(negedge clk);
        total++;
        if (sb.size() != 0 || sw_db !== 2'b01) begin
            bad++;
            $display("FAIL glitch_reject: db=%b pending=%0d, required db=01 pending=0", sw_db, sb.size());
        end
    endtask

    task automatic test_simultaneous();
        int e;
        drive(2'b10, e);
        sb.push_back('{e + 5, 2'b10, 2'b01, 2'b10});
        repeat (6) @(negedge clk);
        total++;
        if (sw_fall !== 2'b01 || sw_rise !== 2'b10 || sw_db !== 2'b10) begin
            bad++;
            $display("FAIL simultaneous: rise=%b fall=%b db=%b, required rise=10 fall=01 db=10", sw_rise, sw_fall, sw_db);
        end
        wait_drain();
    endtask

    task automatic test_reset_mid_count();
        int e;
        drive(2'b11, e);
        repeat (5) @(negedge clk);
        total++;
        if (sw_db !== 2'b10) begin
            bad++;
            $display("FAIL midcount_before: db=%b, required 10", sw_db);
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({sw_db, sw_rise, sw_fall} !== 6'b0) begin
            bad++;
            $display("FAIL midcount_reset: db=%b rise=%b fall=%b, required all 0", sw_db, sw_rise, sw_fall);
        end
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        e = edge_cnt + 1;
        sb.push_back('{e + 5, 2'b11, 2'b00, 2'b11});
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            total++;
            if (sw_db !== 2'b00) begin
                bad++;
                $display("FAIL midcount_early: k=%0d db=%b, required 00", k, sw_db);
            end
        end
        @(negedge clk);
        total++;
        if (sw_db !== 2'b11) begin
            bad++;
            $display("FAIL midcount_latency: db=%b, required 11", sw_db);
        end
        wait_drain();
    endtask

    task automatic test_xor_integration();
        logic [1:0] seq [4];
        logic [1:0] prev;
        logic       exp_c;
        int         e;
        seq = '{2'b00, 2'b01, 2'b10, 2'b11};
        prev = 2'b11;
        c_toggles = 0;
        for (int s = 0; s < 4; s++) begin
            drive(seq[s], e);
            if (seq[s] != prev)
                sb.push_back('{e + 5, seq[s] & ~prev, prev & ~seq[s], seq[s]});
            for (int k = 1; k <= 8; k++) begin
                @(negedge clk);
                exp_c = (k >= 6) ? (seq[s][0] ^ seq[s][1]) : (prev[0] ^ prev[1]);
                total++;
                if (c !== exp_c) begin
                    bad++;
                    $display("FAIL xor_c: raw=%b k=%0d c=%b, required %b", seq[s], k, c, exp_c);
                end
            end
            prev = seq[s];
        end
        total++;
        if (c_toggles != 2 || sb.size() != 0) begin
            bad++;
            $display("FAIL xor_glitch: toggles=%0d pending=%0d, required toggles=2 pending=0", c_toggles, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_clean_rise_fall();
        test_bounce();
        test_glitch();
        test_simultaneous();
        test_reset_mid_count();
        test_xor_integration();
        repeat (3) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_empty: pending=%0d, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule
